// File: rtl/bus16_arbiter.sv
// bus16_arbiter: two-master round-robin arbiter for a shared 16-bit register bus.
// Each master's one-cycle strobe is held in a one-deep request slot. Granted
// requests go out as a single-cycle bus chip select. Read data is routed back to
// the requesting master. A read that gets no slave response completes on timeout
// with fixed data.
module bus16_arbiter #(
  parameter int          RD_TIMEOUT_CLKS = 255,
  parameter logic [15:0] TIMEOUT_DATA    = 16'hDEAD
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst_L,
  input  logic        i_M0_CS,
  input  logic        i_M0_Wr_Rd_n,
  input  logic [15:0] i_M0_Addr8,
  input  logic [15:0] i_M0_Wr_Data,
  output logic [15:0] o_M0_Rd_Data,
  output logic        o_M0_Rd_DV,
  output logic        o_M0_Busy,
  input  logic        i_M1_CS,
  input  logic        i_M1_Wr_Rd_n,
  input  logic [15:0] i_M1_Addr8,
  input  logic [15:0] i_M1_Wr_Data,
  output logic [15:0] o_M1_Rd_Data,
  output logic        o_M1_Rd_DV,
  output logic        o_M1_Busy,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [15:0] o_Bus_Addr8,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Timeout
);

  localparam int            CW        = $clog2(RD_TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(RD_TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  // Master request inputs gathered into index-able form
  logic [1:0]  req_cs_s;
  logic [1:0]  req_wr_s;
  logic [15:0] req_addr_s [2];
  logic [15:0] req_data_s [2];

  assign req_cs_s      = {i_M1_CS, i_M0_CS};
  assign req_wr_s      = {i_M1_Wr_Rd_n, i_M0_Wr_Rd_n};
  assign req_addr_s[0] = i_M0_Addr8;
  assign req_addr_s[1] = i_M1_Addr8;
  assign req_data_s[0] = i_M0_Wr_Data;
  assign req_data_s[1] = i_M1_Wr_Data;

  // Request slots
  logic [1:0]  slot_vld_r;
  logic [1:0]  slot_wr_r;
  logic [15:0] slot_addr_r [2];
  logic [15:0] slot_data_r [2];

  // Arbitration / sequencing state
  state_t        state_r, state_nxt_s;
  logic          grant_r, grant_nxt_s;
  logic          last_r, last_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;

  // Per-cycle control decoded by the FSM
  logic        slot_clr_s;
  logic [1:0]  slot_clr_vec_s;
  logic        bus_issue_s;
  logic        rd_done_s;
  logic [15:0] rd_val_s;
  logic        timeout_nxt_s;

  // Registered outputs
  logic        bus_cs_r, bus_wr_r, m0_dv_r, m1_dv_r, timeout_r;
  logic [15:0] bus_addr_r, bus_wdata_r, m0_data_r, m1_data_r;

  // Next-state and per-cycle control: arbitration, issue, read completion/timeout
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    last_nxt_s     = last_r;
    cnt_nxt_s      = cnt_r;
    slot_clr_s     = 1'b0;
    bus_issue_s    = 1'b0;
    rd_done_s      = 1'b0;
    rd_val_s       = i_Bus_Rd_Data;
    timeout_nxt_s  = 1'b0;
    slot_clr_vec_s = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (slot_vld_r[0] && slot_vld_r[1]) begin
          // Tie: the master that was not granted last wins
          grant_nxt_s = ~last_r;
          last_nxt_s  = ~last_r;
          state_nxt_s = ST_ISSUE;
        end else if (slot_vld_r[0]) begin
          grant_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
          state_nxt_s = ST_ISSUE;
        end else if (slot_vld_r[1]) begin
          grant_nxt_s = 1'b1;
          last_nxt_s  = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        bus_issue_s = 1'b1;
        if (slot_wr_r[grant_r]) begin
          slot_clr_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (i_Bus_Rd_DV) begin
          // Slave data wins even on the limit cycle
          rd_done_s   = 1'b1;
          rd_val_s    = i_Bus_Rd_Data;
          slot_clr_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LIMIT) begin
          rd_done_s     = 1'b1;
          rd_val_s      = TIMEOUT_DATA;
          timeout_nxt_s = 1'b1;
          slot_clr_s    = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (slot_clr_s) begin
      slot_clr_vec_s[grant_r] = 1'b1;
    end else begin
      slot_clr_vec_s = 2'b00;
    end
  end

  // FSM state, grant bookkeeping and read timeout counter
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_r <= ST_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request slots: capture a strobe into an empty slot, clear on completion
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      slot_vld_r     <= 2'b00;
      slot_wr_r      <= 2'b00;
      slot_addr_r[0] <= 16'h0000;
      slot_addr_r[1] <= 16'h0000;
      slot_data_r[0] <= 16'h0000;
      slot_data_r[1] <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_clr_vec_s[i]) begin
          slot_vld_r[i] <= 1'b0;
        end else if (req_cs_s[i] && !slot_vld_r[i]) begin
          slot_vld_r[i]  <= 1'b1;
          slot_wr_r[i]   <= req_wr_s[i];
          slot_addr_r[i] <= req_addr_s[i];
          slot_data_r[i] <= req_data_s[i];
        end
      end
    end
  end

  // Bus-side and master-side output registers
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      bus_cs_r    <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_addr_r  <= 16'h0000;
      bus_wdata_r <= 16'h0000;
      m0_dv_r     <= 1'b0;
      m1_dv_r     <= 1'b0;
      m0_data_r   <= 16'h0000;
      m1_data_r   <= 16'h0000;
      timeout_r   <= 1'b0;
    end else begin
      bus_cs_r  <= bus_issue_s;
      timeout_r <= timeout_nxt_s;
      m0_dv_r   <= rd_done_s & ~grant_r;
      m1_dv_r   <= rd_done_s & grant_r;
      if (bus_issue_s) begin
        bus_wr_r    <= slot_wr_r[grant_r];
        bus_addr_r  <= slot_addr_r[grant_r];
        bus_wdata_r <= slot_data_r[grant_r];
      end
      if (rd_done_s && !grant_r) begin
        m0_data_r <= rd_val_s;
      end
      if (rd_done_s && grant_r) begin
        m1_data_r <= rd_val_s;
      end
    end
  end

  assign o_Bus_CS      = bus_cs_r;
  assign o_Bus_Wr_Rd_n = bus_wr_r;
  assign o_Bus_Addr8   = bus_addr_r;
  assign o_Bus_Wr_Data = bus_wdata_r;
  assign o_M0_Rd_DV    = m0_dv_r;
  assign o_M1_Rd_DV    = m1_dv_r;
  assign o_M0_Rd_Data  = m0_data_r;
  assign o_M1_Rd_Data  = m1_data_r;
  assign o_M0_Busy     = slot_vld_r[0];
  assign o_M1_Busy     = slot_vld_r[1];
  assign o_Timeout     = timeout_r;

endmodule
